wb_ps2_tx: RTL

Wishbone slave that transmits host-to-device command bytes on a PS/2 port (e.g. keyboard LED set `0xED`, reset `0xFF`). It is the transmit counterpart of `wb_ps2`, which only receives. It runs the full host-request sequence:

- clock inhibit,
- start bit,
- data bits clocked by the device,
- odd parity,
- stop bit,
- device acknowledge check.

It sits on a `conbus` slave port next to `wb_ps2` and drives the open-drain PS/2 clock/data lines through output-enable pins.

---
 rtl/wb_ps2_tx_pkg.sv | 39 +++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/wb_ps2_tx.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ps2_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Register offsets decode wb_adr_i[2]; status bits follow the STATUS layout.
package wb_ps2_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAITIDLE
  } state_e;

  localparam logic ADR_DATA   = 1'b0;
  localparam logic ADR_STATUS = 1'b1;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_NACK = 2;
  localparam int unsigned STAT_TMO  = 3;
  localparam int unsigned STAT_OVR  = 4;

  localparam int unsigned FRAME_W = 10;

  typedef struct packed {
    logic [26:0] rsvd;
    logic        ovr;
    logic        tmo;
    logic        nack;
    logic        done;
    logic        busy;
  } status_t;

  // Transmit frame: stop, odd parity, data; shifted out LSB first.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser with falling-edge detect for one PS/2 pad.
// Flops reset high so an idle (released) line produces no spurious fall.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_sync,
  output logic o_fall_c
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync   = r_sync;
  assign o_fall_c = r_prev & ~r_sync;

endmodule

// File: rtl/wb_ps2_tx.sv
// Wishbone slave sending host-to-device PS/2 command bytes over open-drain OEs.
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a stalled frame (sets tmo).
module wb_ps2_tx
  import wb_ps2_tx_pkg::*;
#(
  parameter int unsigned clk_freq   = 100000000,
  parameter int unsigned inhibit_us = 100,
  parameter int unsigned timeout_ms = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic        ps2_clk_oe,
  output logic        ps2_dat_oe,
  output logic        intr
);

  localparam int unsigned INHIBIT_CYCLES = clk_freq / 1000000 * inhibit_us;
  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TMO_CYCLES = clk_freq / 1000 * timeout_ms;

  logic w_clk_sync;
  logic w_clk_fall;
  logic w_dat_sync;
  logic w_unused_dat_fall;

  ps2_line_sync u_clk_sync (
    .clk      (clk),
    .reset    (reset),
    .i_line   (ps2_clk_i),
    .o_sync   (w_clk_sync),
    .o_fall_c (w_clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk      (clk),
    .reset    (reset),
    .i_line   (ps2_dat_i),
    .o_sync   (w_dat_sync),
    .o_fall_c (w_unused_dat_fall)
  );

  state_e               r_state;
  logic [FRAME_W-1:0]   r_frame;
  logic [3:0]           r_bit_cnt;
  logic [INH_W-1:0]     r_inh_cnt;
  logic [7:0]           r_data;
  logic                 r_clk_oe;
  logic                 r_dat_oe;
  logic                 r_done;
  logic                 r_nack;
  logic                 r_ovr;
  logic                 r_intr;
  logic                 r_ack;
  logic [31:0]          r_dat_o;
  logic                 w_tmo;

  logic    w_req;
  logic    w_data_wr;
  logic    w_stat_wr;
  logic    w_busy;
  logic    w_clr_done;
  logic    w_clr_nack;
  logic    w_clr_tmo;
  logic    w_clr_ovr;
  status_t w_status;

  // One access per ack; ack is never asserted on back-to-back cycles.
  assign w_req      = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_data_wr  = w_req & wb_we_i & (wb_adr_i[2] == ADR_DATA);
  assign w_stat_wr  = w_req & wb_we_i & (wb_adr_i[2] == ADR_STATUS);
  assign w_busy     = (r_state != ST_IDLE);
  assign w_clr_done = w_stat_wr & wb_dat_i[STAT_DONE];
  assign w_clr_nack = w_stat_wr & wb_dat_i[STAT_NACK];
  assign w_clr_tmo  = w_stat_wr & wb_dat_i[STAT_TMO];
  assign w_clr_ovr  = w_stat_wr & wb_dat_i[STAT_OVR];

  always_comb begin
    w_status      = '0;
    w_status.busy = w_busy;
    w_status.done = r_done;
    w_status.nack = r_nack;
    w_status.tmo  = w_tmo;
    w_status.ovr  = r_ovr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack   <= 1'b0;
      r_dat_o <= '0;
    end else begin
      r_ack <= w_req;
      if (w_req && !wb_we_i) begin
        r_dat_o <= (wb_adr_i[2] == ADR_STATUS) ? w_status : {24'd0, r_data};
      end
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WDOG_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  logic              r_tmo;
  logic [WDOG_W-1:0] r_wdog;
  assign w_tmo = r_tmo;
`else
  assign w_tmo = 1'b0;
`endif

  // Transfer FSM and sticky status; a hardware set below overrides a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_frame   <= '0;
      r_bit_cnt <= '0;
      r_inh_cnt <= '0;
      r_data    <= '0;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
      r_done    <= 1'b0;
      r_nack    <= 1'b0;
      r_ovr     <= 1'b0;
      r_intr    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      r_tmo     <= 1'b0;
      r_wdog    <= '0;
`endif
    end else begin
      r_intr <= r_done;
      if (w_clr_done) r_done <= 1'b0;
      if (w_clr_nack) r_nack <= 1'b0;
      if (w_clr_ovr)  r_ovr  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      if (w_clr_tmo)  r_tmo  <= 1'b0;
`endif
      if (w_data_wr && w_busy) r_ovr <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          if (w_data_wr) begin
            r_data    <= wb_dat_i[7:0];
            r_frame   <= make_frame(wb_dat_i[7:0]);
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_clk_oe  <= 1'b1;
            r_dat_oe  <= (INHIBIT_CYCLES == 1);
            r_state   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          r_inh_cnt <= r_inh_cnt + INH_W'(1);
          if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 2)) r_dat_oe <= 1'b1;
          if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b1;
            r_state  <= ST_REQ;
`ifdef PS2_TX_TIMEOUT_EN
            r_wdog   <= '0;
`endif
          end
        end
        ST_REQ: begin
          if (w_clk_fall) begin
            r_dat_oe <= ~r_frame[0];
            r_state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          // bit_cnt is the index of the bit currently on the line.
          if (w_clk_fall) begin
            if (r_bit_cnt == 4'd9) begin
              r_dat_oe <= 1'b0;
              r_state  <= ST_ACK;
            end else begin
              r_frame   <= {1'b0, r_frame[FRAME_W-1:1]};
              r_dat_oe  <= ~r_frame[1];
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        ST_ACK: begin
          if (w_clk_fall) begin
            if (w_dat_sync) r_nack <= 1'b1;
            r_state <= ST_WAITIDLE;
          end
        end
        ST_WAITIDLE: begin
          if (w_clk_sync && w_dat_sync) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog covers everything after the request is released to the device.
      if (r_state inside {ST_REQ, ST_SEND, ST_ACK, ST_WAITIDLE}) begin
        r_wdog <= r_wdog + WDOG_W'(1);
        if (r_wdog == WDOG_W'(TMO_CYCLES - 1)) begin
          r_tmo    <= 1'b1;
          r_done   <= r_done & ~w_clr_done;
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_state  <= ST_IDLE;
        end
      end
`endif
    end
  end

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, wb_sel_i, wb_adr_i[31:3], wb_adr_i[1:0], wb_dat_i[31:8],
                         w_unused_dat_fall, w_clr_tmo, (TMO_CYCLES == 0)};

  assign wb_ack_o   = r_ack;
  assign wb_dat_o   = r_dat_o;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;
  assign intr       = r_intr;

endmodule
